// File: rtl/leb128_encoder_pkg.sv
// Shared types and constants for the LEB128 encoder: state encoding, length limits,
// the continuation-bit mask and operand extension / shift helpers.
package leb128_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LEB128_MAX32 = 4'd5;
    localparam logic [3:0] LEB128_MAX64 = 4'd10;
    localparam logic [7:0] LEB128_CONT  = 8'h80;

    // An i32 operand occupies the low word; widen it so one termination rule serves both sizes.
    function automatic logic [63:0] extend_operand(input logic [63:0] data,
                                                   input logic        is_signed,
                                                   input logic        is64);
        logic [63:0] res;
        if (is64) begin
            res = data;
        end else if (is_signed) begin
            res = {{32{data[31]}}, data[31:0]};
        end else begin
            res = {32'h0000_0000, data[31:0]};
        end
        return res;
    endfunction

    function automatic logic [63:0] shift7(input logic [63:0] value, input logic is_signed);
        return {{7{value[63] & is_signed}}, value[63:7]};
    endfunction

endpackage

// File: rtl/leb128_encoder_if.sv
// Request / byte-stream bundle of the LEB128 encoder.
// LEB128_PAD_EN adds the in_pad request field.
interface leb128_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_signed;
    logic        in_is64;
`ifdef LEB128_PAD_EN
    logic        in_pad;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [3:0]  out_len;

`ifdef LEB128_PAD_EN
    modport master (output in_valid, in_data, in_signed, in_is64, in_pad, out_ready,
                    input  in_ready, out_valid, out_data, out_last, out_len);
    modport slave  (input  in_valid, in_data, in_signed, in_is64, in_pad, out_ready,
                    output in_ready, out_valid, out_data, out_last, out_len);
`else
    modport master (output in_valid, in_data, in_signed, in_is64, out_ready,
                    input  in_ready, out_valid, out_data, out_last, out_len);
    modport slave  (input  in_valid, in_data, in_signed, in_is64, out_ready,
                    output in_ready, out_valid, out_data, out_last, out_len);
`endif
endinterface

// File: rtl/leb128_encoder_term_detect.sv
// Combinational end-of-sequence detector: decides whether the byte built from
// shreg[6:0] is the final one, for minimal or fixed-length (padded) encodings.
module leb128_term_detect
    import leb128_encoder_pkg::*;
(
    input  logic [63:0] shreg,
    input  logic        is_signed,
    input  logic [3:0]  count,
    input  logic        is64,
    input  logic        pad,
    output logic        last
);

    logic [63:0] rest_s;
    logic        min_last_s;
    logic        pad_last_s;

    // Minimal encoding stops once the remaining bits are pure sign/zero fill of bit 6.
    always_comb begin
        rest_s     = shift7(shreg, is_signed);
        min_last_s = 1'b0;
        if (is_signed) begin
            min_last_s = ((rest_s == 64'h0) && !shreg[6]) ||
                         ((rest_s == 64'hFFFF_FFFF_FFFF_FFFF) && shreg[6]);
        end else begin
            min_last_s = (rest_s == 64'h0);
        end
        pad_last_s = (count == (is64 ? LEB128_MAX64 : LEB128_MAX32));
        if (pad) begin
            last = pad_last_s;
        end else begin
            last = min_last_s;
        end
    end

endmodule

// File: rtl/leb128_encoder.sv
// Streaming LEB128 encoder: one integer in, its (S|U)LEB128 bytes out on a valid/ready stream.
// Define LEB128_PAD_EN to enable fixed-length padded encodings via in_pad.
module leb128_encoder
    import leb128_encoder_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 10
) (
    input  logic              clk,
    input  logic              reset,
    leb128_encoder_if.slave   bus
);

    state_t      state_r;
    logic [63:0] shreg_r;
    logic        is_signed_r;
    logic        is64_r;
    logic        pad_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [7:0]  out_data_r;
    logic        out_last_r;
    logic [3:0]  out_len_r;

    logic        accept_s;
    logic        fire_s;
    logic        in_pad_s;
    logic [63:0] ext_s;
    logic [63:0] shifted_s;
    logic [63:0] td_shreg_s;
    logic [3:0]  td_count_s;
    logic        td_signed_s;
    logic        td_is64_s;
    logic        td_pad_s;
    logic        td_last_s;

`ifdef LEB128_PAD_EN
    assign in_pad_s = bus.in_pad;
`else
    assign in_pad_s = 1'b0;
`endif

    // Present the detector with the byte about to be loaded, so out_last can be registered.
    always_comb begin
        accept_s  = bus.in_valid & in_ready_r;
        fire_s    = out_valid_r & bus.out_ready;
        ext_s     = extend_operand(bus.in_data, bus.in_signed, bus.in_is64);
        shifted_s = shift7(shreg_r, is_signed_r);
        if (state_r == IDLE) begin
            td_shreg_s  = ext_s;
            td_count_s  = 4'd1;
            td_signed_s = bus.in_signed;
            td_is64_s   = bus.in_is64;
            td_pad_s    = in_pad_s;
        end else begin
            td_shreg_s  = shifted_s;
            td_count_s  = (out_len_r >= 4'(MAX_BYTES)) ? out_len_r : out_len_r + 4'd1;
            td_signed_s = is_signed_r;
            td_is64_s   = is64_r;
            td_pad_s    = pad_r;
        end
    end

    leb128_term_detect u_term (
        .shreg     (td_shreg_s),
        .is_signed (td_signed_s),
        .count     (td_count_s),
        .is64      (td_is64_s),
        .pad       (td_pad_s),
        .last      (td_last_s)
    );

    // Control FSM with registered stream outputs; out_len doubles as the byte counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            shreg_r     <= 64'h0;
            is_signed_r <= 1'b0;
            is64_r      <= 1'b0;
            pad_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
            out_len_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shreg_r     <= ext_s;
                        is_signed_r <= bus.in_signed;
                        is64_r      <= bus.in_is64;
                        pad_r       <= in_pad_s;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_data_r  <= (td_last_s ? 8'h00 : LEB128_CONT) | {1'b0, ext_s[6:0]};
                        out_last_r  <= td_last_s;
                        out_len_r   <= 4'd1;
                        state_r     <= EMIT;
                    end
                end
                EMIT: begin
                    if (fire_s) begin
                        if (out_last_r) begin
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                            out_data_r  <= 8'h00;
                            out_last_r  <= 1'b0;
                            out_len_r   <= 4'd0;
                            state_r     <= IDLE;
                        end else begin
                            shreg_r    <= shifted_s;
                            out_data_r <= (td_last_s ? 8'h00 : LEB128_CONT) | {1'b0, shifted_s[6:0]};
                            out_last_r <= td_last_s;
                            out_len_r  <= td_count_s;
                        end
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    out_len_r   <= 4'd0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_len   = out_len_r;

endmodule
